slot_allocator_8: RTL and testbench
===================================

SLOT_ALLOCATOR_8 -- requirements
Module: slot_allocator_8

Interface
REQ-001 SHALL have parameter RESERVED_MASK, default 8'h00: slots permanently marked busy, never granted.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port alloc_req  input  1  level request for one free slot this cycle.
REQ-005 SHALL have port free_valid  input  1  release request for slot free_idx this cycle.
REQ-006 SHALL have port free_idx  input  3  index of the slot being released.
REQ-007 SHALL have port flush  input  1  synchronous release of all non-reserved slots.
REQ-008 SHALL have port alloc_gnt  output  1  registered one-cycle grant pulse.
REQ-009 SHALL have port alloc_idx  output  3  registered index of granted slot; valid only while alloc_gnt=1.
REQ-010 SHALL have port busy_map  output  8  slot occupancy, bit=1 busy (reserved bits always 1).
REQ-011 SHALL have port used_cnt  output  4  count of allocated non-reserved slots, 0..8.
REQ-012 SHALL have port full  output  1  high when no non-reserved slot is free.
REQ-013 SHALL have port empty  output  1  high when used_cnt=0.
REQ-014 SHALL have port free_err  output  1  registered one-cycle pulse on illegal release.

Function
REQ-015 SHALL hold an 8-bit allocation register; busy_map = allocation register OR RESERVED_MASK.
REQ-016 SHALL select the lowest-index slot whose busy_map bit is 0 (slot 0 highest priority); none found = full.
REQ-017 SHALL, on an edge where alloc_req=1, full=0, and flush=0, set the selected bit, drive alloc_gnt=1 and alloc_idx=selected index in the following cycle.
REQ-018 SHALL drive alloc_gnt=0 in any cycle following an edge with alloc_req=0, full=1, or flush=1; alloc_idx SHALL hold its last value.
REQ-019 SHALL grant at most one slot per cycle; a continuously held alloc_req yields consecutive grants, ascending while lower slots stay busy.
REQ-020 SHALL, on an edge where free_valid=1 and flush=0, clear bit free_idx if it is allocated and non-reserved; otherwise free_err=1 next cycle and the state SHALL be unchanged.
REQ-021 SHALL evaluate allocation against the pre-edge busy_map: a slot freed on the same edge is not grantable until the next cycle, and a simultaneous free with full=1 produces no grant.
REQ-022 SHALL apply a simultaneous legal alloc and free on the same edge together: used_cnt is unchanged; both map bits update.
REQ-023 SHALL, on an edge with flush=1, clear the allocation register, set used_cnt=0, ignore alloc_req and free_valid, and keep free_err=0.
REQ-024 SHALL keep used_cnt equal to popcount of the allocation register at all times, with no wrap beyond 8 or below 0.
REQ-025 SHALL derive full and empty combinationally from the registered state, not from current-cycle inputs.
REQ-026 SHALL never grant a slot that is set in RESERVED_MASK; if RESERVED_MASK=8'hFF, full SHALL be permanently 1.

Reset
REQ-027 SHALL, while rst=1 and asynchronously, clear the allocation register and drive alloc_gnt=0, alloc_idx=0, used_cnt=0, free_err=0, busy_map=RESERVED_MASK, and empty=1.
REQ-028 SHALL, if rst asserts mid-operation, discard all allocations and any pending grant or error pulse; the first grant after release SHALL be the lowest non-reserved slot.

Verification
REQ-029 SHALL cover: rst, then alloc_req held 9 cycles with RESERVED_MASK=0 -> grants idx 0..7 on consecutive cycles, then full=1, used_cnt=8, and no 9th grant.
REQ-030 SHALL cover: slots 0-3 busy, free_idx=1 -> busy_map=8'h0D; the next alloc_req -> alloc_idx=1.
REQ-031 SHALL cover: full with alloc_req=1 and free_valid=1, free_idx=5 on the same edge -> alloc_gnt=0 that cycle, then grant idx 5 on the following cycle.
REQ-032 SHALL cover: free_idx=6 while slot 6 is free -> free_err pulses one cycle; busy_map and used_cnt are unchanged.
REQ-033 SHALL cover: RESERVED_MASK=8'h03 -> the first grant is idx 2; free_idx=0 -> free_err=1; full asserts after 6 grants.
REQ-034 SHALL cover: flush with alloc_req=1 and 5 slots busy -> next cycle used_cnt=0, empty=1, alloc_gnt=0; rst asserted mid-sequence -> outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/slot_allocator_8.sv
// slot_allocator_8: eight-slot allocator. It grants the lowest free slot on
// request and releases slots individually or all at once (flush). Slots
// listed in RESERVED_MASK always read as busy and are never granted.
module slot_allocator_8 #(
    parameter logic [7:0] RESERVED_MASK = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alloc_req,
    input  logic       free_valid,
    input  logic [2:0] free_idx,
    input  logic       flush,
    output logic       alloc_gnt,
    output logic [2:0] alloc_idx,
    output logic [7:0] busy_map,
    output logic [3:0] used_cnt,
    output logic       full,
    output logic       empty,
    output logic       free_err
);

    // Allocation register. It only ever holds non-reserved slots, because a
    // reserved slot is never selected for a grant.
    logic [7:0] alloc_q, alloc_d;
    logic       gnt_q, gnt_d;
    logic [2:0] idx_q, idx_d;
    logic       err_q, err_d;

    // Priority-encoder result, taken from the busy map before the edge
    logic [2:0] sel_idx;
    logic [3:0] pop_cnt;

    assign busy_map  = alloc_q | RESERVED_MASK;
    assign full      = &busy_map;
    assign used_cnt  = pop_cnt;
    assign empty     = (pop_cnt == 4'd0);
    assign alloc_gnt = gnt_q;
    assign alloc_idx = idx_q;
    assign free_err  = err_q;

    // Lowest-index free slot. The loop runs downward so slot 0 wins.
    always_comb begin
        sel_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!busy_map[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    // Occupancy count is the popcount of the allocation register.
    always_comb begin
        pop_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pop_cnt = pop_cnt + {3'd0, alloc_q[i]};
        end
    end

    // Next state. Flush overrides everything. Otherwise the free and the
    // grant both apply. The grant target was free before the edge, so a
    // legal release can never touch the same bit.
    always_comb begin
        alloc_d = alloc_q;
        gnt_d   = 1'b0;
        idx_d   = idx_q;
        err_d   = 1'b0;
        if (flush) begin
            alloc_d = 8'h00;
        end else begin
            if (free_valid) begin
                if (alloc_q[free_idx]) begin
                    alloc_d[free_idx] = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
            if (alloc_req && !full) begin
                alloc_d[sel_idx] = 1'b1;
                gnt_d            = 1'b1;
                idx_d            = sel_idx;
            end
        end
    end

    // State and registered pulse outputs, with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_q <= 8'h00;
            gnt_q   <= 1'b0;
            idx_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            alloc_q <= alloc_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_slot_allocator_8.sv
// Bench for slot_allocator_8. Two instances share one set of inputs: one has
// no reserved slots and the other reserves slots 0 and 1. A behavioural
// model of each instance is compared against it on every falling edge, and
// directed sequences pin the model with hand-computed literals.
module tb_slot_allocator_8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alloc_req = 1'b0;
    logic       free_valid = 1'b0;
    logic [2:0] free_idx = 3'd0;
    logic       flush = 1'b0;

    logic       gnt0, gnt1, err0, err1, full0, full1, empty0, empty1;
    logic [2:0] idx0, idx1;
    logic [7:0] busy0, busy1;
    logic [3:0] used0, used1;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    slot_allocator_8 #(.RESERVED_MASK(8'h00)) u0 (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .free_valid(free_valid),
        .free_idx(free_idx), .flush(flush), .alloc_gnt(gnt0), .alloc_idx(idx0),
        .busy_map(busy0), .used_cnt(used0), .full(full0), .empty(empty0),
        .free_err(err0));

    slot_allocator_8 #(.RESERVED_MASK(8'h03)) u1 (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .free_valid(free_valid),
        .free_idx(free_idx), .flush(flush), .alloc_gnt(gnt1), .alloc_idx(idx1),
        .busy_map(busy1), .used_cnt(used1), .full(full1), .empty(empty1),
        .free_err(err1));

    // ---------------- behavioural model ----------------
    // Each slot is one entry of an array: 1 means allocated.
    bit [7:0] mask_of [2] = '{8'h00, 8'h03};
    bit       m_slot [2][8];
    bit       m_gnt [2];
    int       m_idx [2];
    bit       m_err [2];

    always @(posedge clk or posedge rst) begin : model
        int  pick;
        bit  old_slot [8];
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int s = 0; s < 8; s++) m_slot[k][s] = 1'b0;
                m_gnt[k] = 1'b0;
                m_idx[k] = 0;
                m_err[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int s = 0; s < 8; s++) old_slot[s] = m_slot[k][s];
                pick = -1;
                for (int s = 7; s >= 0; s--)
                    if (!old_slot[s] && !mask_of[k][s]) pick = s;
                m_gnt[k] = 1'b0;
                m_err[k] = 1'b0;
                if (flush) begin
                    for (int s = 0; s < 8; s++) m_slot[k][s] = 1'b0;
                end else begin
                    if (free_valid) begin
                        if (old_slot[free_idx]) m_slot[k][free_idx] = 1'b0;
                        else m_err[k] = 1'b1;
                    end
                    if (alloc_req && pick >= 0) begin
                        m_slot[k][pick] = 1'b1;
                        m_gnt[k] = 1'b1;
                        m_idx[k] = pick;
                    end
                end
            end
        end
    end

    function automatic int exp_busy(int k);
        int b = 0;
        for (int s = 0; s < 8; s++)
            if (m_slot[k][s] || mask_of[k][s]) b += (1 << s);
        return b;
    endfunction

    function automatic int exp_used(int k);
        int c = 0;
        for (int s = 0; s < 8; s++) if (m_slot[k][s]) c++;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m0.gnt", {31'd0, gnt0}, {31'd0, m_gnt[0]});
            check("m0.idx", {29'd0, idx0}, m_idx[0]);
            check("m0.busy", {24'd0, busy0}, exp_busy(0));
            check("m0.used", {28'd0, used0}, exp_used(0));
            check("m0.full", {31'd0, full0}, {31'd0, exp_busy(0) == 255});
            check("m0.empty", {31'd0, empty0}, {31'd0, exp_used(0) == 0});
            check("m0.err", {31'd0, err0}, {31'd0, m_err[0]});
            check("m1.gnt", {31'd0, gnt1}, {31'd0, m_gnt[1]});
            check("m1.idx", {29'd0, idx1}, m_idx[1]);
            check("m1.busy", {24'd0, busy1}, exp_busy(1));
            check("m1.used", {28'd0, used1}, exp_used(1));
            check("m1.full", {31'd0, full1}, {31'd0, exp_busy(1) == 255});
            check("m1.empty", {31'd0, empty1}, {31'd0, exp_used(1) == 0});
            check("m1.err", {31'd0, err1}, {31'd0, m_err[1]});
        end
    end

    task automatic idle();
        alloc_req = 1'b0; free_valid = 1'b0; flush = 1'b0; free_idx = 3'd0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".gnt0"}, {31'd0, gnt0}, 0);
        check({tag, ".idx0"}, {29'd0, idx0}, 0);
        check({tag, ".used0"}, {28'd0, used0}, 0);
        check({tag, ".busy0"}, {24'd0, busy0}, 32'h00);
        check({tag, ".busy1"}, {24'd0, busy1}, 32'h03);
        check({tag, ".empty0"}, {31'd0, empty0}, 1);
        check({tag, ".err0"}, {31'd0, err0}, 0);
        check({tag, ".gnt1"}, {31'd0, gnt1}, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2 check_reset_values("reset");
        cmp_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Hold the request for 9 cycles. u0 grants 0..7; u1 grants 2..7.
        alloc_req = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c < 8) begin
                check("seq.gnt0", {31'd0, gnt0}, 1);
                check("seq.idx0", {29'd0, idx0}, c);
            end else begin
                check("seq.no9th", {31'd0, gnt0}, 0);
            end
            if (c < 6) check("res.idx1", {29'd0, idx1}, c + 2);
            if (c == 4) check("res.notfull", {31'd0, full1}, 0);
            if (c == 5) check("res.full6", {31'd0, full1}, 1);
        end
        check("seq.full0", {31'd0, full0}, 1);
        check("seq.used0", {28'd0, used0}, 8);

        // Flush, then occupy slots 0-3 and release slot 1.
        idle(); flush = 1'b1;
        @(negedge clk);
        check("flush.used0", {28'd0, used0}, 0);
        idle(); alloc_req = 1'b1;
        repeat (4) @(negedge clk);
        idle(); free_valid = 1'b1; free_idx = 3'd1;
        @(negedge clk);
        check("free1.busy0", {24'd0, busy0}, 32'h0D);
        idle(); alloc_req = 1'b1;
        @(negedge clk);
        check("refill.gnt0", {31'd0, gnt0}, 1);
        check("refill.idx0", {29'd0, idx0}, 1);

        // Release an unallocated slot: an error pulse and no state change.
        idle(); free_valid = 1'b1; free_idx = 3'd6;
        @(negedge clk);
        check("bad.err0", {31'd0, err0}, 1);
        check("bad.busy0", {24'd0, busy0}, 32'h0F);
        check("bad.used0", {28'd0, used0}, 4);
        idle();
        @(negedge clk);
        check("bad.pulse", {31'd0, err0}, 0);

        // Releasing a reserved slot is illegal.
        free_valid = 1'b1; free_idx = 3'd0;
        @(negedge clk);
        check("res.err1", {31'd0, err1}, 1);

        // Refill u0 to full: slots 0,4,5,6,7 are granted.
        idle(); alloc_req = 1'b1;
        repeat (5) @(negedge clk);
        check("fill.full0", {31'd0, full0}, 1);
        free_valid = 1'b1; free_idx = 3'd5;
        @(negedge clk);
        check("fullfree.gnt0", {31'd0, gnt0}, 0);
        check("fullfree.busy0", {24'd0, busy0}, 32'hDF);
        free_valid = 1'b0;
        @(negedge clk);
        check("fullfree.next", {31'd0, gnt0}, 1);
        check("fullfree.idx0", {29'd0, idx0}, 5);

        // Release three slots so five remain busy, then flush with requests.
        idle();
        for (int i = 0; i < 3; i++) begin
            free_valid = 1'b1; free_idx = 3'(i);
            @(negedge clk);
        end
        idle();
        check("pre.used0", {28'd0, used0}, 5);
        flush = 1'b1; alloc_req = 1'b1; free_valid = 1'b1; free_idx = 3'd3;
        @(negedge clk);
        check("fl.used0", {28'd0, used0}, 0);
        check("fl.empty0", {31'd0, empty0}, 1);
        check("fl.gnt0", {31'd0, gnt0}, 0);
        check("fl.err0", {31'd0, err0}, 0);
        idle();

        // Random traffic with occasional reset pulses in the middle of a cycle
        for (int n = 0; n < 600; n++) begin
            alloc_req  = ($urandom_range(0, 99) < 60);
            free_valid = ($urandom_range(0, 99) < 45);
            free_idx   = 3'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) == 0 && n > 20) begin
                #3 rst = 1'b1;
                #1 check_reset_values("async");
                @(negedge clk);
                rst = 1'b0;
            end else begin
                @(negedge clk);
            end
        end

        idle();
        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
